// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with redirect/stall priority, plus the IF/ID
// pipeline register feeding decode and a running count of loaded instructions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] imem_rd,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

    logic [31:0] pc_q;
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next;
    ifid_t       ifid_q;
    logic [31:0] count_q;
    logic        ifid_load;

    // Targets are word-aligned here so pc_f[1:0] stays zero whatever the producer sends.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^pc_target_e[1:0];

    assign pc_plus4_f = pc_q + 32'd4;
    assign ifid_load  = !flush_d && !stall_d;

    always_comb begin
        pc_next = pc_q;
        if (pc_src_e)
            pc_next = {pc_target_e[31:2], 2'b00};
        else if (!stall_f)
            pc_next = pc_plus4_f;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= {RESET_PC[31:2], 2'b00};
        else
            pc_q <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_d)
            ifid_q <= BUBBLE;
        else if (!stall_d)
            ifid_q <= '{instr: imem_rd, pc: pc_q, pc_plus4: pc_plus4_f, valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= 32'h0;
        else if (ifid_load)
            count_q <= count_q + 32'd1;
    end

    assign pc_f        = pc_q;
    assign imem_addr   = pc_q;
    assign instr_d     = ifid_q.instr;
    assign pc_d        = ifid_q.pc;
    assign pc_plus4_d  = ifid_q.pc_plus4;
    assign valid_d     = ifid_q.valid;
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), instruction injected into the decode register on reset/flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall_f  input  1  hold PC.
REQ-006 stall_d  input  1  hold IF/ID register.
REQ-007 flush_d  input  1  clear IF/ID register to bubble.
REQ-008 pc_src_e  input  1  redirect request (taken branch/jump).
REQ-009 pc_target_e  input  32  redirect target address.
REQ-010 imem_rd  input  32  instruction word returned combinationally by instruction memory.
REQ-011 imem_addr  output  32  address to instruction memory, identical to pc_f.
REQ-012 pc_f  output  32  current fetch PC.
REQ-013 instr_d  output  32  registered instruction for decode.
REQ-014 pc_d  output  32  PC of instr_d.
REQ-015 pc_plus4_d  output  32  pc_d + 4.
REQ-016 valid_d  output  1  instr_d is a real fetched instruction (not a bubble).
REQ-017 fetch_count  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-018 imem_addr SHALL equal pc_f combinationally; no added latency.
REQ-019 Next-PC priority SHALL be: reset -> RESET_PC; else pc_src_e -> {pc_target_e[31:2],2'b00}; else stall_f -> hold; else pc_f + 4.
REQ-020 Redirect SHALL take effect even when stall_f is high in the same cycle.
REQ-021 PC increment SHALL be modulo 2^32 (32'hFFFFFFFC + 4 -> 32'h00000000); no overflow flag.
REQ-022 pc_f[1:0] SHALL always be 2'b00.
REQ-023 IF/ID priority SHALL be: reset or flush_d -> bubble; else stall_d -> hold all IF/ID outputs; else load instr_d<=imem_rd, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
REQ-024 Bubble SHALL be instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
REQ-025 flush_d SHALL win over simultaneous stall_d.
REQ-026 Instruction latency SHALL be one cycle: word at pc_f in cycle N appears on instr_d in cycle N+1 when loaded.
REQ-027 fetch_count SHALL increment by 1 on each edge where IF/ID loads (not reset, not flush_d, not stall_d); wraps modulo 2^32.
REQ-028 stall_f and stall_d SHALL be independent; no internal coupling between them.
REQ-029 Outputs SHALL not depend combinationally on any input except imem_addr on pc_f state.

Reset
REQ-030 On a rising edge with reset=1: pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_count=0.
REQ-031 Reset SHALL override all other inputs, including mid-stall and mid-redirect.
REQ-032 Asserting reset without a clock edge SHALL not change any state.

Verification
REQ-033 Sequential fetch: reset, release, imem model returns word = address ^ 32'hA5A5A5A5 -> pc_f 0,4,8,C on successive cycles; instr_d lags one cycle; valid_d=1 from second cycle after reset release; fetch_count=3 after 3 loads.
REQ-034 Redirect: at pc_f=8 assert pc_src_e with pc_target_e=32'h00000103 and flush_d -> next pc_f=32'h00000100, instr_d=32'h00000013, valid_d=0, fetch_count unchanged.
REQ-035 Stall: assert stall_f and stall_d for 2 cycles at pc_f=C -> pc_f, instr_d, pc_d, fetch_count held; resume fetch at C then 10.
REQ-036 Priority collisions: stall_f with pc_src_e (target 32'h40) -> pc_f=32'h40; stall_d with flush_d -> bubble.
REQ-037 Wrap: redirect to 32'hFFFFFFFC -> next pc_f=0, pc_plus4_d of that instruction=0.
REQ-038 Reset mid-operation: assert reset during stall with pc_f=32'h40, fetch_count=5 -> all outputs return to REQ-030 values on that edge.
